fine_code_generator: RTL and testbench
======================================

FINE_CODE_GENERATOR -- requirements
Module: fine_code_generator

Interface
REQ-001 Parameter FINE_BITS, 55, width of the raw fine code.
REQ-002 Parameter CODE_W, 7, width of the binary fine code.
REQ-003 Parameter DWELL_W, 8, width of the sweep dwell counter.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_code  input  CODE_W  binary fine code to expand.
REQ-008 in_valid  input  1  in_code is valid this cycle.
REQ-009 in_ready  output  1  block accepts in_code this cycle.
REQ-010 sweep_start  input  1  single-cycle pulse that starts an auto-sweep.
REQ-011 dwell  input  DWELL_W  idle cycles between sweep codes; sampled at sweep_start.
REQ-012 err_clr  input  1  clears err.
REQ-013 out_raw  output  FINE_BITS  generated raw fine code.
REQ-014 out_code  output  CODE_W  binary code that produced out_raw.
REQ-015 out_valid  output  1  out_raw and out_code are valid.
REQ-016 out_ready  input  1  downstream accepts the output.
REQ-017 sweep_busy  output  1  high while a sweep is in progress.
REQ-018 sweep_done  output  1  one-cycle pulse after the last sweep code is accepted.
REQ-019 err  output  1  sticky flag for an out-of-range input code.

Function
REQ-020 Mapping for B in 0..54 SHALL set raw bits [54:55-B] to 1 and all other bits to 0; B=0 gives all zeros.
REQ-021 Mapping for B in 55..109, with M=B-55, SHALL set raw bits [54-M:0] to 1 and all other bits to 0; raw[0]=1 exactly when B>=55.
REQ-022 The output stage SHALL be one register: it loads when out_valid=0 or out_ready=1, and out_valid holds with stable data until accepted.
REQ-023 Transfers SHALL occur on cycles where valid and ready are both 1; in_valid=1 with in_code in range SHALL give out_valid=1 the next cycle (latency 1).
REQ-024 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-025 An accepted in_code in 110..127 SHALL be consumed, produce no output, and set err; err stays set until err_clr.
REQ-026 err_clr and a new error in the same cycle SHALL leave err=1.
REQ-027 FSM states SHALL be IDLE, EMIT and DWELL.
REQ-028 IDLE to EMIT SHALL occur on sweep_start: the step counter loads 0 and dwell is latched.
REQ-029 EMIT SHALL present the step code; when it is accepted: if the step is 109, go to IDLE and pulse sweep_done; else if the latched dwell is 0, increment the step and stay in EMIT; else go to DWELL.
REQ-030 DWELL SHALL count the latched dwell cycles, then increment the step and return to EMIT.
REQ-031 sweep_busy SHALL be 1 in EMIT and DWELL.
REQ-032 sweep_start outside IDLE SHALL be ignored.
REQ-033 In the cycle of a sweep_start, an in_valid input SHALL still be accepted if in_ready=1; the sweep begins the next cycle.
REQ-034 The step counter SHALL never exceed 109 and SHALL not wrap.
REQ-035 out_code SHALL always equal the code from which out_raw was generated.

Reset
REQ-036 While rst_n=0: out_raw=0, out_code=0, out_valid=0, sweep_busy=0, sweep_done=0, err=0, state=IDLE, and step and dwell counters=0.
REQ-037 Reset asserted mid-sweep or mid-stall SHALL abort immediately; any pending output is discarded.
REQ-038 After reset release, in_ready SHALL be 1 in the first cycle.

Structure
REQ-039 Package fine_code_pkg SHALL hold FINE_BITS, CODE_W, CODE_MAX=109, HALF=55 and the FSM state enum.
REQ-040 Sub-module fine_code_expand SHALL be a purely combinational map from code to raw per REQ-020 and REQ-021, instantiated once, with its input muxed between in_code and the step counter.

Verification
REQ-041 in_code=0, 3, 54 with out_ready=1 -> the next cycle out_raw = 55'h0, 55'h70000000000000, 55'h7FFFFFFFFFFFFE respectively.
REQ-042 in_code=55, 109 -> out_raw = 55'h7FFFFFFFFFFFFF, 55'h1; out_code echoes the input.
REQ-043 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid=1, out_raw stable, in_ready=0; then out_ready=1 -> exactly one transfer per cycle and no loss.
REQ-044 in_code=110 -> no out_valid and err=1; err_clr -> err=0; in_code=127 with err_clr in the same cycle -> err=1.
REQ-045 sweep_start with dwell=2 and out_ready=1 -> 110 outputs with codes 0..109 in order, spaced 3 cycles apart; sweep_done pulses once; sweep_busy=0 afterwards; in_ready=0 throughout.
REQ-046 rst_n low at step 40 of a sweep -> all outputs at reset values; after release, state IDLE and a new sweep starts at code 0.

Source files
------------

// File: rtl/fine_code_pkg.sv
// -----------------------------------------------------------------------------
// fine_code_pkg
// Shared constants and types for the fine code generator.
//   FINE_BITS : width of the thermometer-style raw fine code
//   CODE_W    : width of the binary fine code
//   DWELL_W   : width of the sweep dwell counter
//   CODE_MAX  : largest legal binary code (2*FINE_BITS - 1)
//   HALF      : first code of the falling half of the mapping
//   state_e   : sweep FSM states
// -----------------------------------------------------------------------------
package fine_code_pkg;

  localparam int FINE_BITS = 55;
  localparam int CODE_W    = 7;
  localparam int DWELL_W   = 8;
  localparam int CODE_MAX  = 109;
  localparam int HALF      = 55;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    DWELL = 2'd2
  } state_e;

endpackage

// File: rtl/fine_code_generator_if.sv
// -----------------------------------------------------------------------------
// fine_code_generator_if
// Input and output valid/ready streams of the fine code generator.
//   in_code/in_valid/in_ready     : binary code stream into the block
//   out_raw/out_code/out_valid/out_ready : raw code stream out of the block
// Modports:
//   master : the environment (drives codes in, accepts results out)
//   slave  : the generator itself
// -----------------------------------------------------------------------------
interface fine_code_generator_if #(
  parameter int CODE_W    = fine_code_pkg::CODE_W,
  parameter int FINE_BITS = fine_code_pkg::FINE_BITS
);

  logic [CODE_W-1:0]    in_code;
  logic                 in_valid;
  logic                 in_ready;
  logic [FINE_BITS-1:0] out_raw;
  logic [CODE_W-1:0]    out_code;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_code, in_valid, out_ready,
    input  in_ready, out_raw, out_code, out_valid
  );

  modport slave (
    input  in_code, in_valid, out_ready,
    output in_ready, out_raw, out_code, out_valid
  );

endinterface

// File: rtl/fine_code_expand.sv
// -----------------------------------------------------------------------------
// fine_code_expand
// Purely combinational map from a binary fine code to the raw fine code.
//   code 0..HALF-1        : top `code` bits set (code 0 -> all zeros)
//   code HALF..CODE_MAX   : bits [FINE_BITS-1-(code-HALF):0] set
//   code above CODE_MAX   : all zeros (never loaded by the parent)
// Ports:
//   code : binary fine code in
//   raw  : raw fine code out
// -----------------------------------------------------------------------------
module fine_code_expand #(
  parameter int FINE_BITS = fine_code_pkg::FINE_BITS,
  parameter int CODE_W    = fine_code_pkg::CODE_W
) (
  input  logic [CODE_W-1:0]    code,
  output logic [FINE_BITS-1:0] raw
);

  import fine_code_pkg::*;

  localparam logic [FINE_BITS-1:0] ALL_ONES = '1;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    raw = '0;
    if (code < CODE_W'(HALF)) begin
      // Rising half: ones fill in from the MSB downwards.
      raw = ~(ALL_ONES >> code);
    end else if (code <= CODE_W'(CODE_MAX)) begin
      // Falling half: ones drain away from the MSB downwards.
      raw = ALL_ONES >> (code - CODE_W'(HALF));
    end
  end

endmodule

// File: rtl/fine_code_generator.sv
// -----------------------------------------------------------------------------
// fine_code_generator
// Expands binary fine codes into raw fine codes, either from an input stream
// or from an internal auto-sweep over all legal codes with a programmable
// idle gap between codes.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : slave side of the in/out valid-ready streams
//   sweep_start  : pulse that starts a sweep (only honoured in IDLE)
//   dwell        : idle cycles between sweep codes, captured at sweep_start
//   err_clr      : clears the sticky error flag
//   sweep_busy   : high while a sweep runs
//   sweep_done   : one-cycle pulse after the last sweep code is loaded
//   err          : sticky flag for an accepted out-of-range input code
// -----------------------------------------------------------------------------
module fine_code_generator #(
  parameter int FINE_BITS = fine_code_pkg::FINE_BITS,
  parameter int CODE_W    = fine_code_pkg::CODE_W,
  parameter int DWELL_W   = fine_code_pkg::DWELL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fine_code_generator_if.slave bus,
  input  logic                 sweep_start,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 err_clr,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic                 err
);

  import fine_code_pkg::*;

  state_e               state_q, state_d;
  logic [CODE_W-1:0]    step_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   dwell_cnt_q;

  logic [FINE_BITS-1:0] raw_q;
  logic [CODE_W-1:0]    code_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 err_q;

  logic                 load_en;
  logic                 in_ok;
  logic                 in_fire;
  logic                 emit_fire;
  logic                 last_step;
  logic                 dwell_end;
  logic [CODE_W-1:0]    sel_code;
  logic [FINE_BITS-1:0] sel_raw;

  // The output register can take new data when empty or being drained.
  assign load_en   = !valid_q || bus.out_ready;
  assign in_ok     = bus.in_code <= CODE_W'(CODE_MAX);
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign emit_fire = (state_q == EMIT) && load_en;
  assign last_step = step_q == CODE_W'(CODE_MAX);
  assign dwell_end = (state_q == DWELL) && (dwell_cnt_q == DWELL_W'(1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (sweep_start) state_d = EMIT;
      EMIT: begin
        if (emit_fire) begin
          if (last_step)              state_d = IDLE;
          else if (dwell_q != '0)     state_d = DWELL;
        end
      end
      DWELL: if (dwell_end) state_d = EMIT;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    sweep_busy   = 1'b0;
    bus.in_ready = 1'b0;
    unique case (state_q)
      IDLE:    bus.in_ready = load_en;
      EMIT,
      DWELL:   sweep_busy   = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep step and dwell counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sweep_start) begin
            step_q  <= '0;
            dwell_q <= dwell;
          end
        end
        EMIT: begin
          // The step stops at CODE_MAX; the sweep ends instead of wrapping.
          if (emit_fire && !last_step) begin
            if (dwell_q == '0) step_q      <= step_q + CODE_W'(1);
            else               dwell_cnt_q <= dwell_q;
          end
        end
        DWELL: begin
          if (dwell_end) step_q      <= step_q + CODE_W'(1);
          else           dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Shared expander: the sweep owns it in EMIT, the input stream otherwise.
  // ---------------------------------------------------------------------------
  assign sel_code = (state_q == EMIT) ? step_q : bus.in_code;

  fine_code_expand #(
    .FINE_BITS (FINE_BITS),
    .CODE_W    (CODE_W)
  ) u_expand (
    .code (sel_code),
    .raw  (sel_raw)
  );

  // ---------------------------------------------------------------------------
  // Output register, sweep_done pulse and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (load_en) begin
        // Out-of-range input codes are consumed but never produce output.
        if (emit_fire || (in_fire && in_ok)) begin
          raw_q   <= sel_raw;
          code_q  <= sel_code;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end
      done_q <= emit_fire && last_step;
      // A new error wins over a simultaneous clear.
      err_q  <= (err_q && !err_clr) || (in_fire && !in_ok);
    end
  end

  assign bus.out_raw   = raw_q;
  assign bus.out_code  = code_q;
  assign bus.out_valid = valid_q;
  assign sweep_done    = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_fine_code_generator.sv
// -----------------------------------------------------------------------------
// tb_fine_code_generator
// Self-checking bench: directed vector table, backpressure, sweep timing,
// reset abort, then random stream traffic against a queue-based model.
// -----------------------------------------------------------------------------
module tb_fine_code_generator;

  logic       clk;
  logic       rst_n;
  logic       sweep_start;
  logic [7:0] dwell;
  logic       err_clr;
  logic       sweep_busy;
  logic       sweep_done;
  logic       err;

  int n_checks = 0;
  int n_err    = 0;

  // Model: queue of codes held by the output stage, and the sticky error.
  int   q[$];
  logic m_err;

  fine_code_generator_if bus ();

  fine_code_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sweep_start (sweep_start),
    .dwell       (dwell),
    .err_clr     (err_clr),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        v;
    logic [6:0]  code;
    logic        clr;
    logic        exp_valid;
    logic [54:0] exp_raw;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Raw code straight from the mapping rules, bit by bit.
  function automatic logic [54:0] ref_raw(input int b);
    logic [54:0] r;
    for (int i = 0; i < 55; i++) begin
      if (b < 55) r[i] = (i >= 55 - b);
      else        r[i] = (i <= 109 - b);
    end
    return r;
  endfunction

  // One stream cycle, entered and left on a falling edge.
  task automatic step(input logic v, input logic [6:0] c, input logic r, input logic ec);
    bit accept;
    check("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_code", bus.out_code, q[0]);
      check("out_raw", bus.out_raw, ref_raw(q[0]));
    end
    check("err", err, m_err);
    bus.in_valid  = v;
    bus.in_code   = c;
    bus.out_ready = r;
    err_clr       = ec;
    sweep_start   = 1'b0;
    #1;
    check("in_ready", bus.in_ready, (q.size() == 0) || r);
    accept = v && ((q.size() == 0) || r);
    if (q.size() != 0 && r) void'(q.pop_front());
    if (accept && c <= 109) q.push_back(int'(c));
    m_err = (m_err && !ec) || (accept && c > 109);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_raw"}, bus.out_raw, 0);
    check({tag, "_out_code"}, bus.out_code, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_sweep_busy"}, sweep_busy, 0);
    check({tag, "_sweep_done"}, sweep_done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    vec_t       vecs[10];
    logic [6:0] rc;
    bit         found;
    bit         exp_valid;

    vecs[0] = '{1'b1, 7'd0,   1'b0, 1'b1, 55'h0,              1'b0};
    vecs[1] = '{1'b1, 7'd3,   1'b0, 1'b1, 55'h70000000000000, 1'b0};
    vecs[2] = '{1'b1, 7'd54,  1'b0, 1'b1, 55'h7FFFFFFFFFFFFE, 1'b0};
    vecs[3] = '{1'b1, 7'd55,  1'b0, 1'b1, 55'h7FFFFFFFFFFFFF, 1'b0};
    vecs[4] = '{1'b1, 7'd109, 1'b0, 1'b1, 55'h1,              1'b0};
    vecs[5] = '{1'b1, 7'd110, 1'b0, 1'b0, 55'h0,              1'b1};
    vecs[6] = '{1'b0, 7'd0,   1'b1, 1'b0, 55'h0,              1'b0};
    vecs[7] = '{1'b1, 7'd110, 1'b0, 1'b0, 55'h0,              1'b1};
    vecs[8] = '{1'b1, 7'd127, 1'b1, 1'b0, 55'h0,              1'b1};
    vecs[9] = '{1'b0, 7'd0,   1'b1, 1'b0, 55'h0,              1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;
    sweep_start   = 1'b0;
    dwell         = '0;
    err_clr       = 1'b0;
    m_err         = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Directed vector table
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].code, 1'b1, vecs[i].clr);
      check("vec_valid", bus.out_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check("vec_raw", bus.out_raw, vecs[i].exp_raw);
        check("vec_code", bus.out_code, vecs[i].code);
      end
      check("vec_err", err, vecs[i].exp_err);
    end

    // Sweep with dwell=2: one code every third cycle
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    err_clr       = 1'b0;
    dwell         = 8'd2;
    sweep_start   = 1'b1;
    @(negedge clk);
    sweep_start   = 1'b0;
    for (int i = 0; i < 340; i++) begin
      exp_valid = (i >= 1) && ((i - 1) % 3 == 0) && ((i - 1) / 3 <= 109);
      check("sw_busy", sweep_busy, i <= 327);
      if (i <= 327) check("sw_in_ready", bus.in_ready, 0);
      check("sw_valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
        check("sw_code", bus.out_code, (i - 1) / 3);
        check("sw_raw", bus.out_raw, ref_raw((i - 1) / 3));
      end
      check("sw_done", sweep_done, i == 328);
      // A second start mid-sweep must be ignored.
      sweep_start = (i == 100);
      @(negedge clk);
    end
    sweep_start = 1'b0;

    // Reset mid-sweep at step 40
    dwell       = 8'd0;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (bus.out_valid && bus.out_code == 7'd40) found = 1'b1;
      else @(negedge clk);
    end
    check("abort_reached_40", found, 1);
    check("abort_busy", sweep_busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    q.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_idle", sweep_busy, 0);
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    check("resweep_busy", sweep_busy, 1);
    check("resweep_valid0", bus.out_valid, 0);
    @(negedge clk);
    check("resweep_valid1", bus.out_valid, 1);
    check("resweep_code0", bus.out_code, 0);
    check("resweep_raw0", bus.out_raw, ref_raw(0));
    @(negedge clk);
    check("resweep_code1", bus.out_code, 1);
    for (int k = 0; k < 300 && sweep_busy; k++) @(negedge clk);
    check("resweep_end", sweep_busy, 0);
    @(negedge clk);

    // Backpressure: one held result, five stalled cycles, then streaming
    step(1'b1, 7'd17, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 7'($urandom_range(0, 109)), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 7'($urandom_range(0, 109)), 1'b1, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0);

    // Random stream traffic
    for (int k = 0; k < 400; k++) begin
      rc = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(110, 127))
                                       : 7'($urandom_range(0, 109));
      step(1'($urandom_range(0, 1)), rc, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0));
    end
    step(1'b0, 7'd0, 1'b1, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
